// File: rtl/inv_butterfly_stream.sv
// Inverse radix-2 butterfly over a serially received 8-sample block.
// Input is buffered, then (x[k]+x[k+4]) and (x[k]-x[k+4]), optionally halved, are streamed out.
module inv_butterfly_stream #(
  parameter int N     = 4,
  parameter int SCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2**N-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2**N-1:0]  out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int W = 2**N;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t         state_reg, state_next;
  logic [2:0]     icnt_reg, icnt_next;
  logic [2:0]     ocnt_reg, ocnt_next;
  logic           out_valid_reg, out_valid_next;
  logic           out_last_reg, out_last_next;
  logic [W-1:0]   out_data_reg, out_data_next;

  logic [W-1:0]   buf_mem [0:7];

  logic           in_hs;
  logic           out_hs;
  logic [2:0]     calc_idx;
  logic [W-1:0]   calc_a;
  logic [W-1:0]   calc_b;
  logic [W:0]     calc_sum;
  logic [W-1:0]   calc_res;

  assign in_ready = (state_reg == FILL);
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid_reg & out_ready;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  // Index of the sample that the output register loads on the next transfer:
  // j=0 when the block completes, otherwise the successor of the one on display.
  assign calc_idx = (state_reg == FILL) ? 3'd0 : ocnt_reg + 3'd1;
  assign calc_a   = buf_mem[{1'b0, calc_idx[1:0]}];
  assign calc_b   = buf_mem[{1'b1, calc_idx[1:0]}];
  assign calc_sum = calc_idx[2] ? ({calc_a[W-1], calc_a} - {calc_b[W-1], calc_b})
                                : ({calc_a[W-1], calc_a} + {calc_b[W-1], calc_b});
  assign calc_res = (SCALE != 0) ? calc_sum[W:1] : calc_sum[W-1:0];

  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_mem[icnt_reg] <= in_data;
    end
  end

  always_comb begin
    state_next     = state_reg;
    icnt_next      = icnt_reg;
    ocnt_next      = ocnt_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    out_data_next  = out_data_reg;
    case (state_reg)
      FILL: begin
        if (in_hs) begin
          icnt_next = icnt_reg + 3'd1;
          if (icnt_reg == 3'd7) begin
            state_next     = DRAIN;
            icnt_next      = 3'd0;
            ocnt_next      = 3'd0;
            out_valid_next = 1'b1;
            out_last_next  = 1'b0;
            out_data_next  = calc_res;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (ocnt_reg == 3'd7) begin
            state_next     = FILL;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end else begin
            ocnt_next     = ocnt_reg + 3'd1;
            out_data_next = calc_res;
            out_last_next = (ocnt_reg == 3'd6);
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= FILL;
      icnt_reg      <= 3'd0;
      ocnt_reg      <= 3'd0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      icnt_reg      <= icnt_next;
      ocnt_reg      <= ocnt_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      out_data_reg  <= out_data_next;
    end
  end

endmodule

// File: tb/tb_inv_butterfly_stream.sv
// Scoreboard bench: one instance per SCALE setting, both fed the same stream.
module tb_inv_butterfly_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready1, out_valid1, out_last1;
  logic [15:0] out_data1;
  logic        in_ready0, out_valid0, out_last0;
  logic [15:0] out_data0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] blk [8];
  logic [15:0] q1[$];
  logic [15:0] q0[$];

  int          cnt1 = 0, cnt0 = 0;
  bit          stall1 = 0, post1 = 0;
  logic [15:0] held1 = '0;

  always #5 clk = ~clk;

  inv_butterfly_stream #(.N(4), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1), .out_ready(out_ready)
  );

  inv_butterfly_stream #(.N(4), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input int j, input bit sc);
    logic signed [16:0] a, b, s;
    a = {blk[j % 4][15], blk[j % 4]};
    b = {blk[(j % 4) + 4][15], blk[(j % 4) + 4]};
    s = (j < 4) ? a + b : a - b;
    return sc ? s[16:1] : s[15:0];
  endfunction

  task automatic set_blk(input logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7);
    blk[0] = v0; blk[1] = v1; blk[2] = v2; blk[3] = v3;
    blk[4] = v4; blk[5] = v5; blk[6] = v6; blk[7] = v7;
  endtask

  // Called #1 after a rising edge; returns at the falling edge showing j=0 when n==8.
  task automatic send(input int n, input bit gaps);
    int i = 0;
    int t = 0;
    while (i < n && t < 200) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      @(negedge clk);
      if (in_ready1) begin
        if (i == 7) begin
          chk("pre_valid", out_valid1, 0);
          for (int j = 0; j < 8; j++) begin
            q1.push_back(model(j, 1'b1));
            q0.push_back(model(j, 1'b0));
          end
        end
        i++;
      end
      @(posedge clk); #1;
      t++;
      if (gaps && i < n) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", i, n);
    if (n == 8) begin
      @(negedge clk);
      chk("first_valid_s1", out_valid1, 1);
      chk("first_valid_s0", out_valid0, 1);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", (t < 100), 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cnt1 = 0; cnt0 = 0; stall1 = 0; post1 = 0;
    end else begin
      if (stall1) begin
        chk("hold_valid", out_valid1, 1);
        chk("hold_data", out_data1, held1);
      end
      if (post1) chk("ready_after_last", in_ready1, 1);
      if (out_valid1) chk("ready_in_drain", in_ready1, 0);
      post1  = 0;
      stall1 = out_valid1 & ~out_ready;
      held1  = out_data1;
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          chk("spurious_s1", out_valid1, 0);
        end else begin
          logic [15:0] e;
          e = q1.pop_front();
          $display("[TB] s1 out j=%0d data=%h last=%0b", cnt1, out_data1, out_last1);
          chk("data_s1", out_data1, e);
          chk("last_s1", out_last1, (cnt1 == 7));
          if (cnt1 == 7) post1 = 1;
          cnt1 = (cnt1 + 1) % 8;
        end
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          chk("spurious_s0", out_valid0, 0);
        end else begin
          logic [15:0] e;
          e = q0.pop_front();
          $display("[TB] s0 out j=%0d data=%h last=%0b", cnt0, out_data0, out_last0);
          chk("data_s0", out_data0, e);
          chk("last_s0", out_last0, (cnt0 == 7));
          cnt0 = (cnt0 + 1) % 8;
        end
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid1, 0);
    chk("rst_data", out_data1, 0);
    chk("rst_last", out_last1, 0);
    chk("rst_ready", in_ready1, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // basic
    set_blk(1, 2, 3, 4, 5, 6, 7, 8);
    send(8, 1'b0);
    wait_drain();

    // rounding toward -inf
    set_blk(3, 16'hFFFD, 0, 0, 0, 0, 0, 0);
    send(8, 1'b0);
    wait_drain();

    // extremes
    set_blk(16'h7FFF, 16'h8000, 0, 0, 16'h7FFF, 16'h7FFF, 0, 0);
    send(8, 1'b0);
    wait_drain();

    // backpressure on j=2
    set_blk(1, 2, 3, 4, 5, 6, 7, 8);
    send(8, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", out_valid1, 1);
      chk("bp_data", out_data1, 16'd5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // input gaps
    send(8, 1'b1);
    wait_drain();

    // reset during fill
    send(5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete(); q0.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_out_after_partial", out_valid1, 0);
    end
    @(posedge clk); #1;
    send(8, 1'b0);
    wait_drain();

    // reset during drain
    send(8, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("drain_rst_valid", out_valid1, 0);
    chk("drain_rst_last", out_last1, 0);
    chk("drain_rst_ready", in_ready1, 1);
    q1.delete(); q0.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    set_blk(16'h0010, 16'hFFF0, 16'h1234, 16'h8000, 16'h0003, 16'h0020, 16'h4321, 16'h0001);
    send(8, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_butterfly_stream.md
Name: inv_butterfly_stream

Overview:
- Inverse radix-2 butterfly stage for the 8-point IFFT path; the counterpart of the forward add/sub butterfly.
- Receives an 8-sample block serially, x0..x7, where x[k] holds the sum term and x[k+4] the difference term.
- Reconstructs the original operand pairs as (x[k]+x[k+4])/2 and (x[k]-x[k+4])/2, then streams them out with valid/ready handshakes on both sides.

Parameters:
- N, 4, sample width is W = 2**N bits, two's complement.
- SCALE, 1, 1 = arithmetic shift right by 1 after add/sub (exact inverse); 0 = no shift, result truncated to W bits (wraps).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is valid this cycle
- in_data  input  W  input sample, two's complement
- in_ready  output  1  block accepts a sample this cycle
- out_valid  output  1  out_data is valid
- out_data  output  W  output sample, two's complement
- out_last  output  1  high with the 8th output sample of a block
- out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to FILL; input count and output count go to 0.
  - out_valid=0, out_data=0, out_last=0. Buffer contents need not be cleared.
  - in_ready is combinational from state, so it reads 1 during reset.
- Reset mid-operation discards any partial or undrained block. The first sample after reset release is x0 of a new block.
- States:
  - FILL: in_ready=1. An input handshake (in_valid & in_ready) writes buf[icnt] and increments icnt (3 bits). Handshakes may have gaps. When the handshake with icnt=7 occurs, go to DRAIN and set icnt=0.
  - DRAIN: in_ready=0, and in_valid is ignored. Outputs j=0..7 are presented in order.
- Output computation, with sums formed at W+1 bits:
  - For j<4: s = buf[j] + buf[j+4].
  - For j>=4: s = buf[j-4] - buf[j].
  - SCALE=1: out_data = s[W:1], an arithmetic shift that floors toward -inf. Overflow is impossible.
  - SCALE=0: out_data = s[W-1:0].
- Latency and pacing:
  - Output is registered. out_valid first rises the cycle after the 8th input handshake, carrying j=0.
  - An output handshake (out_valid & out_ready) loads j+1 on the next edge, giving 1 sample/cycle when out_ready stays high.
  - While out_ready=0, out_valid, out_data and out_last hold stable.
- out_last=1 only while j=7 is presented.
- After the j=7 handshake: out_valid=0, state returns to FILL, and in_ready=1 in the following cycle. There is no same-cycle overlap of blocks.
- Throughput is 16 cycles per block minimum: 8 fill + 8 drain.
- out_valid never drops without a handshake, except on reset.

Test Plan:
- Basic: reset, then x0..x7 = 1,2,3,4,5,6,7,8 back-to-back with out_ready=1, SCALE=1. Expect:
  - out = 3,4,5,6,0xFFFE,0xFFFE,0xFFFE,0xFFFE.
  - out_valid first high the cycle after the 8th accept; out_last only on the 8th output; in_ready=0 for all 8 drain cycles.
- Rounding: x0=3, x4=0, x1=0xFFFD, x5=0, others 0, SCALE=1. Expect out0=1, out1=0xFFFE, out4=1, out5=0xFFFE.
- Extremes: x0=0x7FFF, x4=0x7FFF, x1=0x8000, x5=0x7FFF, SCALE=1. Expect out0=0x7FFF, out1=0xFFFF, out4=0x0000, out5=0x8000.
- Backpressure: block 1..8, out_ready=0 for 3 cycles while out2 is presented. Expect:
  - out_data holds 5 with out_valid=1 for those cycles.
  - Exactly 8 outputs, correct order, in_ready stays 0 until the cycle after the out_last handshake.
- Input gaps: in_valid toggling 1,0,1,0... over 16 cycles with block 1..8. Expect identical output to the basic case.
- Mid-block reset: accept 5 samples, assert rst for 2 cycles, release, then send block 1..8. Expect:
  - No output during or after the partial block.
  - One output block 3,4,5,6,0xFFFE x4.
- Mid-drain reset: assert rst during drain. Expect out_valid=0 immediately (asynchronous), and in_ready=1.
- SCALE=0 (second instance): block 1..8. Expect out = 6,8,10,12,0xFFFC,0xFFFC,0xFFFC,0xFFFC.
